// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch unit.
package imem_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam int unsigned CNT_W            = 16;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch request/response, load port and status bundle between the IF stage and the
// instruction memory; master = IF stage side, slave = memory side.
interface imem_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();
  import imem_pkg::*;

  logic                  ReqValid;
  logic                  ReqReady;
  logic [31:0]           ReqAddr;
  logic                  Stall;
  logic                  Flush;
  logic                  RspValid;
  logic [DATA_WIDTH-1:0] Instruction;
  logic                  AddrFault;
  logic                  LoadEn;
  logic [31:0]           LoadAddr;
  logic [DATA_WIDTH-1:0] LoadData;
  logic                  Busy;
  logic [CNT_W-1:0]      FetchCount;
  logic [CNT_W-1:0]      StallCount;

  modport master (
    output ReqValid, ReqAddr, Stall, Flush, LoadEn, LoadAddr, LoadData,
    input  ReqReady, RspValid, Instruction, AddrFault, Busy, FetchCount, StallCount
  );

  modport slave (
    input  ReqValid, ReqAddr, Stall, Flush, LoadEn, LoadAddr, LoadData,
    output ReqReady, RspValid, Instruction, AddrFault, Busy, FetchCount, StallCount
  );

endinterface

// File: rtl/imem_array.sv
// DEPTH x DATA_WIDTH instruction storage: one write port, one read port with write-first
// bypass. Power-up contents follow INIT_MODE (0: all NOP_WORD, 1: word i = i*4).
module imem_array import imem_pkg::*; #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           DEPTH      = 128,
  parameter int unsigned           INIT_MODE  = 1,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0,
  localparam int unsigned          IDX_W      = clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] words [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    // Power-up value only; reset never touches memory contents.
    logic [DATA_WIDTH-1:0] word_q = (INIT_MODE == 1) ? DATA_WIDTH'(i * 4) : NOP_WORD;

    always_ff @(posedge clk) begin
      if (we && (waddr == IDX_W'(i))) begin
        word_q <= wdata;
      end
    end

    assign words[i] = word_q;
  end

  assign rdata = (we && (waddr == raddr)) ? wdata : words[raddr];

endmodule

// File: rtl/imem_fetch_unit.sv
// Synchronous-read instruction memory with request/response fetch handshake, wait states,
// stall hold, flush and run-time load port. Optional counters under `IMEM_PERF_EN.
module imem_fetch_unit import imem_pkg::*; #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH       = 128,
  parameter int unsigned           WAIT_STATES = 0,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD    = DATA_WIDTH'(NOP_WORD_DEFAULT),
  parameter int unsigned           INIT_MODE   = 1
) (
  input logic              Clk,
  input logic              Reset,
  imem_fetch_unit_if.slave bus
);

  localparam int unsigned IDX_W      = clog2(DEPTH);
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

  state_e                state_q;
  logic [3:0]            wait_cnt_q;
  logic [31:0]           addr_q;
  logic                  rsp_valid_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] instr_q;

  logic [31:0]           rd_addr;
  logic                  rd_fault;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] capture_word;
  logic                  accept;
  logic                  load_we;

  assign bus.ReqReady = (state_q == IDLE) || ((state_q == RESP) && !bus.Stall);
  assign accept       = bus.ReqValid && bus.ReqReady && !bus.Flush;

  // Reads from the live request when entering RESP directly, else from the latched address.
  assign rd_addr      = (state_q == WAIT) ? addr_q : bus.ReqAddr;
  assign rd_fault     = (rd_addr[1:0] != 2'b00) || (rd_addr >= ADDR_LIMIT);
  assign capture_word = rd_fault ? NOP_WORD : rd_word;
  assign load_we      = bus.LoadEn && (bus.LoadAddr < ADDR_LIMIT);

  imem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .INIT_MODE  (INIT_MODE),
    .NOP_WORD   (NOP_WORD)
  ) u_array (
    .clk   (Clk),
    .we    (load_we),
    .waddr (bus.LoadAddr[IDX_W+1:2]),
    .wdata (bus.LoadData),
    .raddr (rd_addr[IDX_W+1:2]),
    .rdata (rd_word)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      fault_q     <= 1'b0;
      instr_q     <= NOP_WORD;
    end else if (bus.Flush) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            instr_q     <= capture_word;
            fault_q     <= rd_fault;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        default: begin
          if (accept) begin
            addr_q <= bus.ReqAddr;
            if (WAIT_STATES > 0) begin
              state_q     <= WAIT;
              wait_cnt_q  <= 4'(WAIT_STATES - 1);
              rsp_valid_q <= 1'b0;
            end else begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              instr_q     <= capture_word;
              fault_q     <= rd_fault;
            end
          end else if (bus.ReqReady) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.RspValid    = rsp_valid_q;
  assign bus.Instruction = instr_q;
  assign bus.AddrFault   = fault_q;
  assign bus.Busy        = (state_q != IDLE);

`ifdef IMEM_PERF_EN
  logic [CNT_W-1:0] fetch_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (fetch_cnt_q != '1)) begin
        fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
      end
      if (rsp_valid_q && bus.Stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.FetchCount = fetch_cnt_q;
  assign bus.StallCount = stall_cnt_q;
`else
  assign bus.FetchCount = '0;
  assign bus.StallCount = '0;
`endif

endmodule

// File: tb/tb_imem_fetch_unit.sv
// Bench for imem_fetch_unit: directed steps on a 0- and a 2-wait-state instance, then
// randomized fetches/loads checked against a transaction-level memory model.
module tb_imem_fetch_unit;
  import imem_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 128;
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  imem_fetch_unit_if #(.DATA_WIDTH(DW)) bus0 ();
  imem_fetch_unit_if #(.DATA_WIDTH(DW)) bus2 ();

  imem_fetch_unit #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(0), .NOP_WORD(NOP), .INIT_MODE(1)
  ) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));

  imem_fetch_unit #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .WAIT_STATES(2), .NOP_WORD(NOP), .INIT_MODE(1)
  ) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

  // Fetch-side inputs go to the selected instance only; loads go to both.
  logic        sel;
  logic        req_valid, stall, flush, load_en;
  logic [31:0] req_addr, load_addr, load_data;

  assign bus0.ReqValid = !sel && req_valid;
  assign bus0.ReqAddr  = req_addr;
  assign bus0.Stall    = !sel && stall;
  assign bus0.Flush    = !sel && flush;
  assign bus0.LoadEn   = load_en;
  assign bus0.LoadAddr = load_addr;
  assign bus0.LoadData = load_data;
  assign bus2.ReqValid = sel && req_valid;
  assign bus2.ReqAddr  = req_addr;
  assign bus2.Stall    = sel && stall;
  assign bus2.Flush    = sel && flush;
  assign bus2.LoadEn   = load_en;
  assign bus2.LoadAddr = load_addr;
  assign bus2.LoadData = load_data;

  logic        rsp_valid, req_ready, fault, busy;
  logic [31:0] instr;
  logic [15:0] fetch_cnt, stall_cnt;

  assign rsp_valid = sel ? bus2.RspValid    : bus0.RspValid;
  assign req_ready = sel ? bus2.ReqReady    : bus0.ReqReady;
  assign fault     = sel ? bus2.AddrFault   : bus0.AddrFault;
  assign busy      = sel ? bus2.Busy        : bus0.Busy;
  assign instr     = sel ? bus2.Instruction : bus0.Instruction;
  assign fetch_cnt = sel ? bus2.FetchCount  : bus0.FetchCount;
  assign stall_cnt = sel ? bus2.StallCount  : bus0.StallCount;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] model_mem [DEPTH];
  int          exp_fetch [2];
  int          exp_stall [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rsp(input string tag, input logic v, input logic [31:0] w, input logic f);
    chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
    chk({tag, "_instr"}, instr, w);
    chk({tag, "_fault"}, 32'(fault), 32'(f));
  endtask

  // Counters read as zero unless the performance option is built in.
  function automatic logic [31:0] pv(input int v);
    logic [31:0] r;
    r = 32'(v);
`ifndef IMEM_PERF_EN
    r = '0;
`endif
    return r;
  endfunction

  function automatic logic exp_fault(input logic [31:0] a);
    return (a % 4 != 0) || (a >= LIMIT);
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return exp_fault(a) ? NOP : model_mem[(a / 4) % DEPTH];
  endfunction

  function automatic logic [31:0] pick_addr();
    int r;
    r = $urandom_range(0, 7);
    if (r <= 4) return 32'($urandom_range(0, DEPTH - 1)) * 4;
    if (r == 5) return 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
    if (r == 6) return LIMIT + 32'($urandom_range(0, 255)) * 4;
    return $urandom;
  endfunction

  task automatic cyc();
    @(negedge Clk);
  endtask

  task automatic rand_fetch(input int ws);
    logic [31:0] a, w, la, ld;
    logic        f;
    int          lat, ns, si;
    si = sel ? 1 : 0;
    if ($urandom_range(0, 2) == 0) begin
      la = ($urandom_range(0, 3) == 0) ? LIMIT + 32'($urandom_range(0, 1023))
                                       : 32'($urandom_range(0, DEPTH * 4 - 1));
      ld = $urandom;
      load_en = 1'b1; load_addr = la; load_data = ld;
      cyc();
      load_en = 1'b0;
      if (la < LIMIT) model_mem[(la / 4) % DEPTH] = ld;
    end
    a = pick_addr();
    f = exp_fault(a);
    w = exp_word(a);
    chk("rnd_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = a;
    lat = 0;
    do begin
      cyc();
      lat++;
      req_valid = 1'b0;
    end while (rsp_valid !== 1'b1 && lat < 10);
    chk("rnd_latency", 32'(lat), 32'(ws + 1));
    chk_rsp("rnd", 1'b1, w, f);
    exp_fetch[si]++;
    ns = $urandom_range(0, 3);
    stall = (ns > 0);
    for (int k = 0; k < ns; k++) begin
      cyc();
      chk_rsp("rnd_hold", 1'b1, w, f);
      exp_stall[si]++;
    end
    stall = 1'b0;
    cyc();
    chk("rnd_idle", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a4 [3];
    logic [31:0] w4 [3];
    logic        f4 [3];

    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'(i) * 4;
    exp_fetch = '{0, 0};
    exp_stall = '{0, 0};
    sel = 1'b0; req_valid = 1'b0; req_addr = '0; stall = 1'b0; flush = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    Reset = 1'b0;
    repeat (2) cyc();

    // Reset state of both instances
    chk("rst0_valid", 32'(bus0.RspValid), 32'd0);
    chk("rst0_instr", bus0.Instruction, NOP);
    chk("rst0_fault", 32'(bus0.AddrFault), 32'd0);
    chk("rst0_busy", 32'(bus0.Busy), 32'd0);
    chk("rst0_fcnt", 32'(bus0.FetchCount), 32'd0);
    chk("rst0_scnt", 32'(bus0.StallCount), 32'd0);
    chk("rst2_valid", 32'(bus2.RspValid), 32'd0);
    chk("rst2_busy", 32'(bus2.Busy), 32'd0);
    Reset = 1'b1;
    cyc();

    // Back-to-back fetches, zero wait states
    req_valid = 1'b1; req_addr = 32'h00;
    cyc(); chk_rsp("b2b0", 1'b1, 32'h0, 1'b0); req_addr = 32'h04;
    cyc(); chk_rsp("b2b1", 1'b1, 32'h4, 1'b0); req_addr = 32'h08;
    cyc(); chk_rsp("b2b2", 1'b1, 32'h8, 1'b0); req_valid = 1'b0;
    cyc(); chk("b2b_idle", 32'(rsp_valid), 32'd0); chk("b2b_busy", 32'(busy), 32'd0);
    exp_fetch[0] += 3;

    // Two wait states
    sel = 1'b1;
    chk("ws_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_addr = 32'h10;
    cyc(); req_valid = 1'b0;
    chk("ws_ready1", 32'(req_ready), 32'd0); chk("ws_valid1", 32'(rsp_valid), 32'd0);
    chk("ws_busy1", 32'(busy), 32'd1);
    cyc();
    chk("ws_ready2", 32'(req_ready), 32'd0); chk("ws_valid2", 32'(rsp_valid), 32'd0);
    cyc(); chk_rsp("ws_rsp", 1'b1, 32'h10, 1'b0);
    cyc(); chk("ws_idle", 32'(rsp_valid), 32'd0);
    exp_fetch[1] += 1;

    // Stall hold for four cycles with a competing request
    sel = 1'b0;
    req_valid = 1'b1; req_addr = 32'h20;
    cyc(); chk_rsp("stall_first", 1'b1, 32'h20, 1'b0);
    stall = 1'b1; req_addr = 32'h24;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk_rsp("stall_hold", 1'b1, 32'h20, 1'b0);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    exp_fetch[0] += 1; exp_stall[0] += 4;
    chk("stall_scnt", 32'(stall_cnt), pv(exp_stall[0]));
    chk("stall_fcnt", 32'(fetch_cnt), pv(exp_fetch[0]));
    stall = 1'b0; req_valid = 1'b0;
    cyc(); chk("stall_release", 32'(rsp_valid), 32'd0);

    // Range boundary and misalignment
    a4 = '{32'h1FC, 32'h202, 32'h200};
    w4 = '{32'h1FC, NOP, NOP};
    f4 = '{1'b0, 1'b1, 1'b1};
    req_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_addr = a4[k];
      cyc(); chk_rsp("fault", 1'b1, w4[k], f4[k]);
    end
    req_valid = 1'b0; cyc();
    exp_fetch[0] += 3;

    // Load on the RESP-entry edge is forwarded, then persists; out-of-range load dropped
    req_valid = 1'b1; req_addr = 32'h0C;
    load_en = 1'b1; load_addr = 32'h0C; load_data = 32'hDEAD_BEEF;
    cyc(); load_en = 1'b0;
    chk_rsp("wfirst", 1'b1, 32'hDEAD_BEEF, 1'b0);
    model_mem[3] = 32'hDEAD_BEEF;
    load_en = 1'b1; load_addr = LIMIT + 32'h0C; load_data = 32'h1234_5678;
    cyc(); load_en = 1'b0;
    chk_rsp("reload", 1'b1, 32'hDEAD_BEEF, 1'b0);
    req_valid = 1'b0; cyc();
    exp_fetch[0] += 2;

    // Flush during WAIT
    sel = 1'b1;
    req_valid = 1'b1; req_addr = 32'h14;
    cyc(); req_valid = 1'b0; flush = 1'b1;
    chk("flw_busy", 32'(busy), 32'd1);
    cyc(); flush = 1'b0;
    chk("flw_valid", 32'(rsp_valid), 32'd0); chk("flw_busy2", 32'(busy), 32'd0);
    chk("flw_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      cyc(); chk("flw_stale", 32'(rsp_valid), 32'd0);
    end
    exp_fetch[1] += 1;

    // Flush beats a request, and beats Stall in RESP
    sel = 1'b0;
    req_valid = 1'b1; req_addr = 32'h18; flush = 1'b1;
    cyc(); req_valid = 1'b0; flush = 1'b0;
    chk("flr_valid", 32'(rsp_valid), 32'd0); chk("flr_busy", 32'(busy), 32'd0);
    req_valid = 1'b1; req_addr = 32'h30;
    cyc(); req_valid = 1'b0; stall = 1'b1; flush = 1'b1;
    chk_rsp("fls_pre", 1'b1, 32'h30, 1'b0);
    cyc(); stall = 1'b0; flush = 1'b0;
    chk("fls_valid", 32'(rsp_valid), 32'd0); chk("fls_busy", 32'(busy), 32'd0);
    exp_fetch[0] += 1; exp_stall[0] += 1;
    chk("fls_fcnt", 32'(fetch_cnt), pv(exp_fetch[0]));
    chk("fls_scnt", 32'(stall_cnt), pv(exp_stall[0]));

    // Reset during RESP
    req_valid = 1'b1; req_addr = 32'h10;
    cyc(); req_valid = 1'b0; Reset = 1'b0;
    chk("rsr_pre", 32'(rsp_valid), 32'd1);
    cyc(); Reset = 1'b1;
    chk_rsp("rsr", 1'b0, NOP, 1'b0);
    chk("rsr_busy", 32'(busy), 32'd0);
    chk("rsr_fcnt", 32'(fetch_cnt), 32'd0);
    exp_fetch = '{0, 0};
    exp_stall = '{0, 0};
    for (int k = 0; k < 2; k++) begin
      cyc(); chk("rsr_stale", 32'(rsp_valid), 32'd0);
    end

    // Randomized fetches and loads on both instances
    for (int s = 0; s < 2; s++) begin
      sel = (s == 1);
      cyc();
      for (int n = 0; n < 30; n++) rand_fetch(s == 1 ? 2 : 0);
      chk("rnd_fcnt", 32'(fetch_cnt), pv(exp_fetch[s]));
      chk("rnd_scnt", 32'(stall_cnt), pv(exp_stall[s]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
